rr_request_encoder: RTL and testbench

Round-robin 4:1 request encoder: the inverse of the 2-to-4 address decoder. It samples four request lines, selects one winner with a rotating priority pointer, and presents the winner's 2-bit address on a registered valid/ready interface. The output is held stable until accepted. The block sits in front of the decoder, and its address bits drive the decoder's address0/address1 directly.

---
 rtl/rr_request_encoder_pkg.sv | 16 +
 rtl/rr_request_encoder_pick4.sv | 29 ++
 rtl/rr_request_encoder.sv | 77 +++++++
 tb/tb_rr_request_encoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rr_request_encoder_pkg.sv
// Shared constants and types for the round-robin 4:1 request encoder.
package rr_request_encoder_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned PTR_W   = 2;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rr_state_t;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/rr_request_encoder_pick4.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick4
  import rr_request_encoder_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = ptr + PTR_W'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_request_encoder.sv
// Round-robin 4:1 request encoder with registered valid/ready output.
module rr_request_encoder
  import rr_request_encoder_pkg::*;
#(
  parameter int unsigned PTR_RESET = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic ready,
  output logic address0,
  output logic address1,
  output logic valid
);

  rr_state_t        state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] addr;
  logic [PTR_W-1:0] pick_ptr;
  logic [PTR_W-1:0] winner;
  logic             any;
  logic             accept;

  assign accept = (state == HOLD) && ready;

  // On accept the search starts just past the word being retired.
  assign pick_ptr = accept ? ptr_next(addr) : ptr;

  rr_pick4 u_pick (
    .req    ({in3, in2, in1, in0}),
    .ptr    (pick_ptr),
    .winner (winner),
    .any    (any)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= PTR_W'(PTR_RESET);
      addr  <= '0;
      valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && any) begin
            addr  <= winner;
            state <= HOLD;
            valid <= 1'b1;
          end
        end
        HOLD: begin
          if (ready) begin
            ptr <= ptr_next(addr);
            if (enable && any) begin
              addr <= winner;
            end else begin
              state <= IDLE;
              valid <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign address0 = addr[0];
  assign address1 = addr[1];

endmodule

// File: tb/tb_rr_request_encoder.sv
// Scoreboard bench for rr_request_encoder: independent cycle model plus directed expectations.
module tb_rr_request_encoder;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic in0, in1, in2, in3;
  logic ready;
  logic address0, address1, valid;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       v;
    logic [1:0] a;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic       m_valid;
  logic [1:0] m_addr;
  int         m_ptr;

  always #5 clk = ~clk;

  rr_request_encoder #(.PTR_RESET(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .in0      (in0),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .ready    (ready),
    .address0 (address0),
    .address1 (address1),
    .valid    (valid)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int model_pick(input logic [3:0] req, input int start);
    int k;
    k = 0;
    while (k < 4) begin
      if (req[(start + k) % 4]) return (start + k) % 4;
      k++;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_addr  = 2'd0;
    m_ptr   = 0;
  endtask

  // Called at posedge+1: drive inputs, predict, push, then sample after the edge.
  task automatic run_cycle(input logic en, input logic [3:0] req, input logic rdy);
    exp_t e;
    int   w;
    enable = en;
    {in3, in2, in1, in0} = req;
    ready = rdy;
    if (!m_valid) begin
      w = model_pick(req, m_ptr);
      if (en && w >= 0) begin
        m_addr  = 2'(w);
        m_valid = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = (int'(m_addr) + 1) % 4;
      w = model_pick(req, m_ptr);
      if (en && w >= 0) m_addr = 2'(w);
      else m_valid = 1'b0;
    end
    e.v = m_valid;
    e.a = m_addr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_eq("sb_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      check_eq("sb_valid", {7'd0, valid}, {7'd0, e.v});
      check_eq("sb_addr", {6'd0, address1, address0}, {6'd0, e.a});
    end
  endtask

  function automatic logic [7:0] cur_addr();
    return {6'd0, address1, address0};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int exp_fair[6] = '{0, 1, 2, 3, 0, 1};
    reset = 1'b1;
    enable = 1'b0;
    {in3, in2, in1, in0} = 4'b0;
    ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_eq("rst_valid", {7'd0, valid}, 8'd0);
    check_eq("rst_addr", cur_addr(), 8'd0);
    reset = 1'b0;

    // fairness: all requests, ready high
    for (int i = 0; i < 6; i++) begin
      run_cycle(1'b1, 4'b1111, 1'b1);
      check_eq("fair_addr", cur_addr(), 8'(exp_fair[i]));
    end
    run_cycle(1'b1, 4'b0000, 1'b1);
    check_eq("fair_idle", {7'd0, valid}, 8'd0);

    // backpressure: pointer now 2
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 4'b0010, 1'b0);
      check_eq("bp_hold", cur_addr(), 8'd1);
    end
    run_cycle(1'b0, 4'b1000, 1'b0);
    check_eq("bp_frozen", cur_addr(), 8'd1);
    check_eq("bp_valid", {7'd0, valid}, 8'd1);
    run_cycle(1'b1, 4'b1000, 1'b1);
    check_eq("bp_next", cur_addr(), 8'd3);
    run_cycle(1'b1, 4'b0000, 1'b1);

    // enable gating: pointer now 0
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 4'b0001, 1'b1);
      check_eq("en_gate", {7'd0, valid}, 8'd0);
    end
    run_cycle(1'b1, 4'b0001, 1'b0);
    check_eq("en_addr", cur_addr(), 8'd0);
    run_cycle(1'b1, 4'b0000, 1'b1);

    // wrap-around: pointer 1 -> capture 2, accept -> ptr 3
    run_cycle(1'b1, 4'b0100, 1'b0);
    check_eq("wrap_first", cur_addr(), 8'd2);
    run_cycle(1'b1, 4'b1001, 1'b1);
    check_eq("wrap_w3", cur_addr(), 8'd3);
    run_cycle(1'b1, 4'b1001, 1'b1);
    check_eq("wrap_w0", cur_addr(), 8'd0);
    run_cycle(1'b1, 4'b0000, 1'b1);

    // sparse: only in2, back-to-back accepts
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b1, 4'b0100, 1'b1);
      check_eq("sparse_addr", cur_addr(), 8'd2);
      check_eq("sparse_valid", {7'd0, valid}, 8'd1);
    end
    run_cycle(1'b1, 4'b0000, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      run_cycle(($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 1)));
    end

    // reset mid-cycle while holding a word
    run_cycle(1'b1, 4'b0010, 1'b0);
    run_cycle(1'b1, 4'b0010, 1'b0);
    check_eq("pre_rst_valid", {7'd0, valid}, 8'd1);
    #3;
    reset = 1'b1;
    #1;
    check_eq("async_rst_valid", {7'd0, valid}, 8'd0);
    check_eq("async_rst_addr", cur_addr(), 8'd0);
    sb.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_cycle(1'b1, 4'b0100, 1'b0);
    check_eq("post_rst_valid", {7'd0, valid}, 8'd1);
    check_eq("post_rst_addr", cur_addr(), 8'd2);
    run_cycle(1'b1, 4'b0000, 1'b1);
    // pointer back at PTR_RESET after reset then one accept of 2 -> 3
    run_cycle(1'b1, 4'b1111, 1'b0);
    check_eq("post_rst_ptr", cur_addr(), 8'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
